mem_a_loader: RTL and testbench

//  Stage directly upstream of the banked matrix-A buffer. Accepts A-tile data as an
//  AXI4-Stream (one WIDTH-bit element per beat, row-major). Scatters the beats

---
 rtl/mem_a_loader_if.sv | 13 +
 rtl/mem_a_loader.sv | 114 +++++++++++
 tb/tb_mem_a_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_a_loader_if.sv
// AXI4-Stream element channel feeding the matrix-A loader.
// The master drives data, the slave (loader) answers with tready.
interface mem_a_loader_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/mem_a_loader.sv
// Scatters a row-major A tile round-robin across the banked buffer write port
// and holds tile_ready until the consumer acknowledges the tile.
//
// state | meaning
// IDLE  | waiting for start with a non-zero row count
// LOAD  | accepting stream beats, one buffer write per accepted beat
// FULL  | tile resident; stream stalled until tile_ack
module mem_a_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int BANKS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   cfg_rows,
  mem_a_loader_if.slave            s_axis,
  output logic [BANKS-1:0]         weA,
  output logic [BANKS-1:0]         enA,
  output logic [$clog2(DEPTH)-1:0] addrA,
  output logic [WIDTH-1:0]         dinA,
  output logic                     tile_ready,
  input  logic                     tile_ack,
  output logic                     busy,
  output logic                     err_len
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = AW + 1;
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t        state;
  logic [RW-1:0] rows_q;
  logic [BW-1:0] bank_ptr;
  logic [AW-1:0] row_ptr;

  logic          beat;
  logic          last_bank;
  logic          last_row;
  logic          final_beat;
  logic [RW-1:0] rows_clamped;

  assign beat         = (state == LOAD) && s_axis.tvalid && s_axis.tready;
  assign last_bank    = (bank_ptr == BW'(BANKS - 1));
  assign last_row     = (RW'(row_ptr) == (rows_q - RW'(1)));
  assign final_beat   = last_bank && last_row;
  assign rows_clamped = (cfg_rows > RW'(DEPTH)) ? RW'(DEPTH) : cfg_rows;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rows_q        <= '0;
      bank_ptr      <= '0;
      row_ptr       <= '0;
      weA           <= '0;
      enA           <= '0;
      addrA         <= '0;
      dinA          <= '0;
      tile_ready    <= 1'b0;
      busy          <= 1'b0;
      err_len       <= 1'b0;
      s_axis.tready <= 1'b0;
    end else begin
      // write strobes are single-cycle; address and data hold between beats
      weA <= '0;
      enA <= '0;
      if (beat) begin
        weA   <= BANKS'(1) << bank_ptr;
        enA   <= BANKS'(1) << bank_ptr;
        addrA <= row_ptr;
        dinA  <= s_axis.tdata;
      end

      case (state)
        IDLE: begin
          if (start && (cfg_rows != '0)) begin
            rows_q        <= rows_clamped;
            bank_ptr      <= '0;
            row_ptr       <= '0;
            state         <= LOAD;
            busy          <= 1'b1;
            s_axis.tready <= 1'b1;
          end
        end
        LOAD: begin
          if (beat) begin
            if (last_bank) begin
              bank_ptr <= '0;
              if (!last_row) row_ptr <= row_ptr + AW'(1);
            end else begin
              bank_ptr <= bank_ptr + BW'(1);
            end
            if (s_axis.tlast || final_beat) begin
              state         <= FULL;
              s_axis.tready <= 1'b0;
            end
            if (s_axis.tlast != final_beat) err_len <= 1'b1;
          end
        end
        FULL: begin
          if (tile_ack) begin
            state      <= IDLE;
            tile_ready <= 1'b0;
            busy       <= 1'b0;
          end else begin
            tile_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_a_loader.sv
// Bench for mem_a_loader: random/sequenced tiles compared against a queue
// model of the expected bank/row write sequence.
module tb_mem_a_loader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int BANKS = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             tile_ack = 1'b0;
  logic [AW:0]      cfg_rows = '0;
  logic [BANKS-1:0] weA, enA;
  logic [AW-1:0]    addrA;
  logic [WIDTH-1:0] dinA;
  logic             tile_ready, busy, err_len;

  mem_a_loader_if #(.WIDTH(WIDTH)) s_axis ();

  mem_a_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .s_axis     (s_axis),
    .weA        (weA),
    .enA        (enA),
    .addrA      (addrA),
    .dinA       (dinA),
    .tile_ready (tile_ready),
    .tile_ack   (tile_ack),
    .busy       (busy),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BANKS-1:0] we;
    logic [BANKS-1:0] en;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] din;
  } wr_t;

  wr_t              obs_q[$];
  wr_t              exp_q[$];
  logic [WIDTH-1:0] beat_data[$];
  int               checks = 0;
  int               passes = 0;
  bit               model_err = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    if (weA != '0 || enA != '0) begin
      w = {weA, enA, addrA, dinA};
      obs_q.push_back(w);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic gen_data(input int n, input bit seq);
    beat_data.delete();
    for (int k = 0; k < n; k++) beat_data.push_back(seq ? WIDTH'(k) : WIDTH'($urandom));
  endtask

  // element k of a tile lands in bank k mod BANKS, row k div BANKS
  task automatic build_exp(input int n);
    wr_t e;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      e.we   = BANKS'(1) << (k % BANKS);
      e.en   = e.we;
      e.addr = AW'(k / BANKS);
      e.din  = beat_data[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int rows);
    @(negedge clk);
    obs_q.delete();
    cfg_rows = (AW+1)'(rows);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    tile_ack = 1'b1;
    @(negedge clk);
    tile_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // returns on the falling edge right after the n-th accepted beat
  task automatic send_beats(input int n, input int tlast_at, input int gap_pct);
    int  k = 0;
    int  cyc = 0;
    bit  v;
    while (k < n && cyc < 4 * n + 200) begin
      @(negedge clk);
      cyc++;
      v = ($urandom_range(99) >= gap_pct);
      s_axis.tvalid = v;
      s_axis.tdata  = beat_data[k];
      s_axis.tlast  = (k == tlast_at);
      if (v && s_axis.tready) k++;
    end
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    if (k < n) begin
      checks++;
      $display("FAIL send_timeout accepted %0d want %0d", k, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({weA, enA, addrA, dinA, tile_ready, busy, err_len, s_axis.tready} !== '0)
      $display("FAIL reset_outputs got we=%h en=%h addr=%h din=%h rdy=%b busy=%b err=%b trdy=%b want all 0",
               weA, enA, addrA, dinA, tile_ready, busy, err_len, s_axis.tready);
    else passes++;
    rst_n = 1'b1;
    do_start(0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_axis.tready !== 1'b0)
      $display("FAIL zero_rows_start busy=%b tready=%b want 0 0", busy, s_axis.tready);
    else passes++;
    do_ack();
    checks++;
    if (busy !== 1'b0 || tile_ready !== 1'b0)
      $display("FAIL idle_ack busy=%b tile_ready=%b want 0 0", busy, tile_ready);
    else passes++;
  endtask

  task automatic test_basic();
    int bad = -1;
    gen_data(32, 1'b1);
    build_exp(32);
    do_start(2);
    checks++;
    if (busy !== 1'b1 || s_axis.tready !== 1'b1)
      $display("FAIL basic_load_entry busy=%b tready=%b want 1 1", busy, s_axis.tready);
    else passes++;
    send_beats(32, 31, 0);
    checks++;
    if (tile_ready !== 1'b0 || s_axis.tready !== 1'b0 || weA !== 16'h8000 || addrA !== AW'(1))
      $display("FAIL basic_last_write rdy=%b trdy=%b we=%h addr=%0d want 0 0 8000 1",
               tile_ready, s_axis.tready, weA, addrA);
    else passes++;
    @(negedge clk);
    checks++;
    if (tile_ready !== 1'b1 || weA !== '0)
      $display("FAIL basic_tile_ready rdy=%b we=%h want 1 0", tile_ready, weA);
    else passes++;
    checks++;
    if (err_len !== 1'b0) $display("FAIL basic_err_len got %b want 0", err_len);
    else passes++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL basic_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) $display("FAIL basic_wr_seq idx %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
      else passes++;
    end
    do_ack();
    checks++;
    if (busy !== 1'b0 || tile_ready !== 1'b0)
      $display("FAIL basic_ack busy=%b rdy=%b want 0 0", busy, tile_ready);
    else passes++;
  endtask

  task automatic test_gaps();
    int bad = -1;
    gen_data(64, 1'b0);
    build_exp(64);
    do_start(4);
    send_beats(64, 63, 50);
    @(negedge clk);
    checks++;
    if (tile_ready !== 1'b1 || err_len !== model_err)
      $display("FAIL gaps_end rdy=%b err=%b want 1 %b", tile_ready, err_len, model_err);
    else passes++;
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL gaps_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) $display("FAIL gaps_wr_seq idx %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
      else passes++;
    end
    do_ack();
  endtask

  task automatic test_early_tlast();
    int bad = -1;
    gen_data(11, 1'b0);
    build_exp(11);
    model_err = 1'b1;
    do_start(1);
    send_beats(11, 10, 20);
    checks++;
    if (s_axis.tready !== 1'b0) $display("FAIL early_tready got %b want 0", s_axis.tready);
    else passes++;
    @(negedge clk);
    checks++;
    if (tile_ready !== 1'b1 || err_len !== model_err)
      $display("FAIL early_full rdy=%b err=%b want 1 %b", tile_ready, err_len, model_err);
    else passes++;
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL early_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) $display("FAIL early_wr_seq idx %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
      else passes++;
    end
    do_ack();
    checks++;
    if (busy !== 1'b0 || err_len !== 1'b1)
      $display("FAIL early_sticky busy=%b err=%b want 0 1", busy, err_len);
    else passes++;
  endtask

  task automatic test_missing_tlast();
    int bad = -1;
    apply_reset();
    checks++;
    if (err_len !== 1'b0) $display("FAIL missing_err_clear got %b want 0", err_len);
    else passes++;
    gen_data(16, 1'b0);
    build_exp(16);
    model_err = 1'b1;
    do_start(1);
    send_beats(16, -1, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (tile_ready !== 1'b1 || err_len !== model_err || s_axis.tready !== 1'b0)
      $display("FAIL missing_full rdy=%b err=%b trdy=%b want 1 %b 0",
               tile_ready, err_len, s_axis.tready, model_err);
    else passes++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL missing_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) $display("FAIL missing_wr_seq idx %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
      else passes++;
    end
    do_ack();
  endtask

  task automatic test_full_depth();
    int bad = -1;
    apply_reset();
    gen_data(DEPTH * BANKS, 1'b0);
    build_exp(DEPTH * BANKS);
    do_start(DEPTH);
    send_beats(DEPTH * BANKS, DEPTH * BANKS - 1, 10);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() == 0 || obs_q[$].addr !== AW'(DEPTH - 1) || obs_q[$].we !== 16'h8000)
      $display("FAIL depth_last_write size=%0d", obs_q.size());
    else passes++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL depth_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) $display("FAIL depth_wr_seq idx %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
      else passes++;
    end
    do_start(3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tile_ready !== 1'b1 || s_axis.tready !== 1'b0 || err_len !== model_err)
      $display("FAIL depth_start_in_full busy=%b rdy=%b trdy=%b err=%b want 1 1 0 %b",
               busy, tile_ready, s_axis.tready, err_len, model_err);
    else passes++;
    @(negedge clk);
    tile_ack = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    tile_ack = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_axis.tready !== 1'b0 || tile_ready !== 1'b0)
      $display("FAIL depth_ack_start busy=%b trdy=%b rdy=%b want 0 0 0", busy, s_axis.tready, tile_ready);
    else passes++;
    // row count above DEPTH is clamped, so this reloads a full-depth tile from row 0
    gen_data(DEPTH * BANKS, 1'b0);
    build_exp(DEPTH * BANKS);
    do_start(DEPTH + 5);
    send_beats(DEPTH * BANKS, DEPTH * BANKS - 1, 0);
    repeat (2) @(negedge clk);
    bad = -1;
    checks++;
    if (obs_q.size() != exp_q.size() || tile_ready !== 1'b1 || err_len !== model_err)
      $display("FAIL clamp_end count %0d want %0d rdy=%b err=%b", obs_q.size(), exp_q.size(),
               tile_ready, err_len);
    else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) $display("FAIL clamp_wr_seq idx %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
      else passes++;
    end
    do_ack();
  endtask

  task automatic test_reset_mid_load();
    int bad = -1;
    model_err = 1'b1;
    gen_data(7, 1'b0);
    do_start(2);
    send_beats(7, -1, 0);
    rst_n = 1'b0;
    model_err = 1'b0;
    #1;
    checks++;
    if ({weA, enA, addrA, dinA, tile_ready, busy, err_len, s_axis.tready} !== '0)
      $display("FAIL midrst_outputs we=%h addr=%h din=%h busy=%b trdy=%b want all 0",
               weA, addrA, dinA, busy, s_axis.tready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    gen_data(16, 1'b0);
    build_exp(16);
    do_start(1);
    send_beats(16, 15, 30);
    repeat (2) @(negedge clk);
    checks++;
    if (tile_ready !== 1'b1 || err_len !== model_err)
      $display("FAIL midrst_reload rdy=%b err=%b want 1 %b", tile_ready, err_len, model_err);
    else passes++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL midrst_wr_count got %0d want %0d", obs_q.size(), exp_q.size());
    else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) $display("FAIL midrst_wr_seq idx %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
      else passes++;
    end
    do_ack();
  endtask

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_early_tlast();
    test_missing_tlast();
    test_full_depth();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
